// File: rtl/bcd_display_writer.sv
// Binary-to-BCD feeder for the six-digit 7-segment Avalon-MM slave: accepts a value,
// converts it with a one-bit-per-cycle double-dabble engine and issues one write.
module bcd_display_writer #(
  parameter int         BIN_WIDTH = 20,
  parameter int         DIGITS    = 6,
  parameter logic [1:0] ADDR      = 2'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIN_WIDTH-1:0] in_data,
  output logic [1:0]           avm_address,
  output logic                 avm_write,
  output logic [31:0]          avm_writedata,
  input  logic                 avm_waitrequest,
  output logic                 busy,
  output logic                 overflow,
  output logic [1:0]           dbg_state
);

  localparam int         BCD_W   = 4 * DIGITS;
  localparam int         CNT_W   = $clog2(BIN_WIDTH);
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS) - 64'd1;

  // in_valid/in_ready: a value is taken on any edge where both are high; in_ready is
  // high only in IDLE. avm_write holds with stable address/data until an edge with
  // avm_waitrequest low, which completes the single write for that value.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_WRITE   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [BIN_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]     r_bcd;
  logic [BCD_W-1:0]     w_bcd_adj;
  logic [BCD_W-1:0]     w_bcd_shift;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_in_ready;
  logic                 r_avm_write;
  logic [31:0]          r_wdata;
  logic                 r_busy;
  logic                 r_overflow;
  logic                 w_accept;
  logic                 w_last_iter;
  logic                 w_done;
  logic                 w_ovf_in;

  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_last_iter = (r_state == S_CONVERT) && (r_cnt == CNT_W'(BIN_WIDTH - 1));
  assign w_done      = (r_state == S_WRITE) && !avm_waitrequest;
  assign w_ovf_in    = 64'(in_data) > MAX_VAL;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_bcd_shift = {w_bcd_adj[BCD_W-2:0], r_bin[BIN_WIDTH-1]};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_accept)    w_next_state = S_CONVERT;
      S_CONVERT: if (w_last_iter) w_next_state = S_WRITE;
      S_WRITE:   if (w_done)      w_next_state = S_IDLE;
      default:                    w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Saturated inputs are replaced by 10^DIGITS-1 so the engine itself yields all nines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_avm_write <= 1'b0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == S_IDLE);
      r_busy      <= (w_next_state != S_IDLE);
      r_avm_write <= (w_next_state == S_WRITE);
      if (w_accept) begin
        r_bin      <= w_ovf_in ? MAX_VAL[BIN_WIDTH-1:0] : in_data;
        r_bcd      <= '0;
        r_cnt      <= '0;
        r_overflow <= w_ovf_in;
      end else if (r_state == S_CONVERT) begin
        r_bin <= r_bin << 1;
        r_bcd <= w_bcd_shift;
        r_cnt <= r_cnt + 1'b1;
        if (w_last_iter) r_wdata <= 32'(w_bcd_shift);
      end
    end
  end

  assign in_ready      = r_in_ready;
  assign avm_address   = ADDR;
  assign avm_write     = r_avm_write;
  assign avm_writedata = r_wdata;
  assign busy          = r_busy;
  assign overflow      = r_overflow;
  assign dbg_state     = r_state;

endmodule
